// File: rtl/seq_detector_cfg.sv
// Runtime-programmable serial pattern detector.
// Detects a 1..MAX_LEN-bit pattern on a valid-qualified bit stream, in
// overlapping or non-overlapping mode. It emits a registered one-cycle match
// pulse and keeps a saturating match counter. A host write loads a new
// configuration; a write with an out-of-range length is rejected and
// reported with a one-cycle cfg_err pulse.
module seq_detector_cfg #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter int unsigned          CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(4'b0110),
  parameter int unsigned          DEF_LEN     = 4,
  localparam int unsigned         LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] hist_q,    hist_d;
  logic [LW-1:0]      fill_q,    fill_d;
  logic [MAX_LEN-1:0] pat_q,     pat_d;
  logic [LW-1:0]      len_q,     len_d;
  logic               ovl_q,     ovl_d;
  logic               match_q,   match_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               err_q,     err_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic               accept;
  logic               enough;
  logic               hit;
  logic               cfg_ok;

  // Compare the history plus the incoming bit against the active pattern.
  always_comb begin
    window = {hist_q[MAX_LEN-2:0], x};
    mask   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    accept = en && !cfg_we;
    enough = ((LW+1)'(fill_q) + (LW+1)'(1)) >= (LW+1)'(len_q);
    hit    = accept && enough && (((window ^ pat_q) & mask) == '0);
    cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
  end

  // Next-state logic for stream history, configuration and outputs.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    match_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (cfg_we) begin
      // A config write swallows any stream bit presented in the same cycle.
      if (cfg_ok) begin
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        fill_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      hist_d = window;
      fill_d = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
      if (hit) begin
        match_d = 1'b1;
        if (!ovl_q) begin
          fill_d = '0;
        end
      end
    end

    // Clear takes effect before a coincident hit is counted.
    if (cnt_clr) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers, asynchronously reset to the default config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PATTERN;
      len_q   <= LW'(DEF_LEN);
      ovl_q   <= 1'b1;
      match_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_cfg.sv
// Table-driven bench for seq_detector_cfg, plus hand-written sequences for
// mid-stream reset and counter saturation on a narrow-counter instance.
module tb_seq_detector_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, x = 1'b0, cfg_we = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;

  logic       match, cfg_err, match2, cfg_err2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  seq_detector_cfg #(.MAX_LEN(8), .CNT_W(8), .DEF_PATTERN(8'b0110), .DEF_LEN(4)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match), .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detector_cfg #(.MAX_LEN(8), .CNT_W(2), .DEF_PATTERN(8'b0110), .DEF_LEN(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match2), .match_count(match_count2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en, x, we;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl, clr;
    logic       em;
    logic [7:0] ec;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Present one cycle of inputs, then sample just after the edge.
  task automatic drive(input logic e, input logic xx, input logic we, input logic [7:0] p,
                       input logic [3:0] l, input logic o, input logic c);
    en = e; x = xx; cfg_we = we; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic e, input logic xx, input logic we,
                     input logic [7:0] p, input logic [3:0] l, input logic o, input logic c,
                     input logic em, input logic [7:0] ec, input logic ee);
    vec_t v;
    v.name = name; v.en = e; v.x = xx; v.we = we; v.pat = p; v.len = l; v.ovl = o;
    v.clr = c; v.em = em; v.ec = ec; v.ee = ee;
    tbl.push_back(v);
  endtask

  task automatic bit_in(input string name, input logic b, input logic em, input logic [7:0] ec);
    add(name, 1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, em, ec, 1'b0);
  endtask

  task automatic idle(input string name, input logic b, input logic [7:0] ec);
    add(name, 1'b0, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, ec, 1'b0);
  endtask

  initial begin
    // Test 1: defaults 0110/4/overlap
    bit_in("t1b1", 0, 0, 0); bit_in("t1b2", 1, 0, 0); bit_in("t1b3", 1, 0, 0);
    bit_in("t1b4", 0, 1, 1); bit_in("t1b5", 1, 0, 1); bit_in("t1b6", 1, 0, 1);
    bit_in("t1b7", 0, 1, 2);
    // Test 2: non-overlap
    add("t2cfg", 0, 0, 1, 8'b0110, 4'd4, 0, 0, 0, 2, 0);
    bit_in("t2b1", 0, 0, 2); bit_in("t2b2", 1, 0, 2); bit_in("t2b3", 1, 0, 2);
    bit_in("t2b4", 0, 1, 3); bit_in("t2b5", 1, 0, 3); bit_in("t2b6", 1, 0, 3);
    bit_in("t2b7", 0, 0, 3);
    add("t2clr", 0, 0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 0);
    // Test 3: idle cycles with x toggling
    add("t3cfg", 0, 0, 1, 8'b0110, 4'd4, 1, 0, 0, 0, 0);
    idle("t3i1", 1, 0); bit_in("t3b1", 0, 0, 0);
    idle("t3i2", 1, 0); bit_in("t3b2", 1, 0, 0);
    idle("t3i3", 0, 0); bit_in("t3b3", 1, 0, 0);
    idle("t3i4", 1, 0); bit_in("t3b4", 0, 1, 1);
    idle("t3i5", 0, 1);
    // Test 4: 101/3, rejected writes, full-length pattern
    add("t4cfg", 0, 0, 1, 8'b0000_0101, 4'd3, 1, 0, 0, 1, 0);
    bit_in("t4b1", 1, 0, 1); bit_in("t4b2", 0, 0, 1); bit_in("t4b3", 1, 1, 2);
    bit_in("t4b4", 0, 0, 2); bit_in("t4b5", 1, 1, 3);
    add("t4rej0", 0, 0, 1, 8'hFF, 4'd0, 0, 0, 0, 3, 1);
    idle("t4errclr", 0, 3);
    add("t4rej9", 0, 0, 1, 8'hFF, 4'd9, 0, 0, 0, 3, 1);
    bit_in("t4k1", 0, 0, 3); bit_in("t4k2", 1, 1, 4);
    add("t4cfg8", 0, 0, 1, 8'hA5, 4'd8, 1, 0, 0, 4, 0);
    bit_in("t4f1", 1, 0, 4); bit_in("t4f2", 0, 0, 4); bit_in("t4f3", 1, 0, 4);
    bit_in("t4f4", 0, 0, 4); bit_in("t4f5", 0, 0, 4); bit_in("t4f6", 1, 0, 4);
    bit_in("t4f7", 0, 0, 4); bit_in("t4f8", 1, 1, 5);
    // Test 6b: cfg_we beats en
    add("t6cfgen", 1, 0, 1, 8'b0110, 4'd4, 1, 0, 0, 5, 0);
    bit_in("t6a1", 1, 0, 5); bit_in("t6a2", 1, 0, 5); bit_in("t6a3", 0, 0, 5);
    bit_in("t6c1", 0, 0, 5); bit_in("t6c2", 1, 0, 5); bit_in("t6c3", 1, 0, 5);
    add("t6rejen", 1, 0, 1, 8'hFF, 4'd0, 0, 0, 0, 5, 1);
    bit_in("t6c4", 0, 1, 6);

    // Reset state
    #2;
    chk("rst_match", match, 0); chk("rst_count", match_count, 0);
    chk("rst_err", cfg_err, 0); chk("rst_count2", match_count2, 0);
    @(posedge clk); #1; rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].x, tbl[i].we, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].clr);
      chk({tbl[i].name, ".match"}, match, tbl[i].em);
      chk({tbl[i].name, ".count"}, match_count, tbl[i].ec);
      chk({tbl[i].name, ".err"}, cfg_err, tbl[i].ee);
    end

    // Mid-stream reset: partial 0,1,1 is lost
    drive(1, 0, 0, 8'h00, 4'd0, 0, 0);
    drive(1, 1, 0, 8'h00, 4'd0, 0, 0);
    drive(1, 1, 0, 8'h00, 4'd0, 0, 0);
    en = 1'b0; rst = 1'b1;
    #2;
    chk("mrst_async_count", match_count, 0);
    chk("mrst_async_match", match, 0);
    @(posedge clk); #1; rst = 1'b0;
    drive(1, 0, 0, 8'h00, 4'd0, 0, 0); chk("mrst_b0", match, 0);
    drive(1, 0, 0, 8'h00, 4'd0, 0, 0); chk("mrst_s1", match, 0);
    drive(1, 1, 0, 8'h00, 4'd0, 0, 0); chk("mrst_s2", match, 0);
    drive(1, 1, 0, 8'h00, 4'd0, 0, 0); chk("mrst_s3", match, 0);
    drive(1, 0, 0, 8'h00, 4'd0, 0, 0); chk("mrst_s4", match, 1);
    chk("mrst_count", match_count, 1);

    // Test 5: len=1 non-overlap on the 2-bit counter instance
    drive(0, 0, 1, 8'h01, 4'd1, 0, 1);
    chk("t5cfg_cnt2", match_count2, 0);
    for (int k = 1; k <= 5; k++) begin
      drive(1, 1, 0, 8'h00, 4'd0, 0, 0);
      chk($sformatf("t5b%0d.match2", k), match2, 1);
      chk($sformatf("t5b%0d.count2", k), match_count2, (k < 3) ? k : 3);
    end
    drive(1, 0, 0, 8'h00, 4'd0, 0, 0);
    chk("t5zero.match2", match2, 0); chk("t5zero.count2", match_count2, 3);
    drive(1, 1, 0, 8'h00, 4'd0, 0, 1);
    chk("t5clrhit.match2", match2, 1); chk("t5clrhit.count2", match_count2, 1);
    drive(0, 0, 0, 8'h00, 4'd0, 0, 1);
    chk("t5clr.count2", match_count2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
